// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and memory (slave).
// One req/ack transaction at a time; rdata is valid in the ack cycle.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [1:0]        bus_be;
    logic [15:0]       bus_wdata;
    logic              bus_ack;
    logic [15:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns single load/store requests into req/ack transactions
// on the 16-bit memory bus, handling byte lanes and sign/zero extension, and
// writes loaded data back through the register-file memory port.
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to split misaligned word
// accesses into two byte transactions; otherwise they are rejected with fault.
module load_store_unit #(
    parameter int unsigned ADDR_W      = 16,
    parameter logic [3:0]  RESET_INDEX = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_store,
    input  logic                      op_byte,
    input  logic                      op_signed,
    input  logic [3:0]                reg_index,
    input  logic [ADDR_W-1:0]         addr,
    output logic                      busy,
    output logic                      done,
    output logic                      fault,
    output logic [3:0]                memory_index,
    output logic [15:0]               memory_load,
    output logic                      memory_load_en,
    input  logic [15:0]               memory_store,
    load_store_unit_if.master         bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ACCESS,
`ifdef LSU_MISALIGNED_SPLIT_EN
        S_ACCESS2,
`endif
        S_WRITEBACK
    } state_t;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t            state;
    logic              st_store;
    logic              st_byte;
    logic              st_signed;
    logic [ADDR_W-1:0] st_addr;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              st_split;
    logic [7:0]        lo_byte;
    logic [7:0]        hi_byte;
`endif

    logic misaligned_c;
    logic reject_c;

    // Word access at an odd address; rejected unless splitting is built in.
    assign misaligned_c = !op_byte && addr[0];
    assign reject_c     = start && misaligned_c && !SPLIT_EN;

    // Byte enables for the first (or only) beat of an access.
    function automatic logic [1:0] lane_be(input logic is_byte, input logic a0);
        if (!is_byte && !a0) return 2'b11;
        else if (a0)         return 2'b10;
        else                 return 2'b01;
    endfunction

    // Load result for a single-beat access: word, or steered and extended byte.
    function automatic logic [15:0] load_result(input logic is_byte, input logic sgn,
                                                input logic a0, input logic [15:0] rdata);
        logic [7:0] b;
        if (!is_byte) return rdata;
        b = a0 ? rdata[15:8] : rdata[7:0];
        return {{8{sgn & b[7]}}, b};
    endfunction

    // Request sequencer with registered bus and register-file port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            st_store       <= 1'b0;
            st_byte        <= 1'b0;
            st_signed      <= 1'b0;
            st_addr        <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            st_split       <= 1'b0;
            lo_byte        <= 8'h00;
            hi_byte        <= 8'h00;
`endif
            busy           <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
            memory_index   <= RESET_INDEX;
            memory_load    <= 16'h0000;
            memory_load_en <= 1'b0;
            bus.bus_req    <= 1'b0;
            bus.bus_we     <= 1'b0;
            bus.bus_addr   <= '0;
            bus.bus_be     <= 2'b00;
            bus.bus_wdata  <= 16'h0000;
        end else begin
            done           <= 1'b0;
            fault          <= 1'b0;
            memory_load_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (reject_c) begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end else if (start) begin
                        st_store     <= op_store;
                        st_byte      <= op_byte;
                        st_signed    <= op_signed;
                        st_addr      <= addr;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        st_split     <= misaligned_c;
`endif
                        memory_index <= reg_index;
                        busy         <= 1'b1;
                        if (op_store) begin
                            state <= S_LATCH;
                        end else begin
                            state        <= S_ACCESS;
                            bus.bus_req  <= 1'b1;
                            bus.bus_we   <= 1'b0;
                            bus.bus_addr <= {addr[ADDR_W-1:1], 1'b0};
                            bus.bus_be   <= lane_be(op_byte, addr[0]);
                        end
                    end
                end
                S_LATCH: begin
                    state        <= S_ACCESS;
                    bus.bus_req  <= 1'b1;
                    bus.bus_we   <= 1'b1;
                    bus.bus_addr <= {st_addr[ADDR_W-1:1], 1'b0};
                    bus.bus_be   <= lane_be(st_byte, st_addr[0]);
                    // Byte (and first split) beats carry the low byte in both lanes.
                    if (st_byte || st_addr[0])
                        bus.bus_wdata <= {memory_store[7:0], memory_store[7:0]};
                    else
                        bus.bus_wdata <= memory_store;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    hi_byte <= memory_store[15:8];
`endif
                end
                S_ACCESS: begin
                    if (bus.bus_ack) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (st_split) begin
                            state         <= S_ACCESS2;
                            bus.bus_addr  <= st_addr + ADDR_W'(1);
                            bus.bus_be    <= 2'b01;
                            bus.bus_wdata <= {hi_byte, hi_byte};
                            lo_byte       <= bus.bus_rdata[15:8];
                        end else
`endif
                        begin
                            bus.bus_req <= 1'b0;
                            bus.bus_we  <= 1'b0;
                            bus.bus_be  <= 2'b00;
                            done        <= 1'b1;
                            if (st_store) begin
                                state        <= S_IDLE;
                                busy         <= 1'b0;
                                memory_index <= RESET_INDEX;
                            end else begin
                                state          <= S_WRITEBACK;
                                memory_load    <= load_result(st_byte, st_signed, st_addr[0],
                                                              bus.bus_rdata);
                                memory_load_en <= 1'b1;
                            end
                        end
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                S_ACCESS2: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        bus.bus_be  <= 2'b00;
                        done        <= 1'b1;
                        if (st_store) begin
                            state        <= S_IDLE;
                            busy         <= 1'b0;
                            memory_index <= RESET_INDEX;
                        end else begin
                            state          <= S_WRITEBACK;
                            memory_load    <= {bus.bus_rdata[7:0], lo_byte};
                            memory_load_en <= 1'b1;
                        end
                    end
                end
`endif
                S_WRITEBACK: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    memory_index <= RESET_INDEX;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side counterpart of the register file's load/store port. It drives the register-file memory port: index select, load data and load enable, and it consumes the register file's store data. It turns single load/store requests from the control unit into req/ack transactions on the 16-bit memory bus. It handles byte/word size, byte-lane steering, and sign/zero extension, and writes loaded data back to the register file.

Parameters:
ADDR_W, 16, byte-address width of bus_addr.
RESET_INDEX, 0, value driven on memory_index while idle and after reset.

Ports:
clk  input  Clock  codebase clock bundle; all state updates on rising edge of clk.ph0
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; accepted only when busy=0
op_store  input  1  1=store, 0=load
op_byte  input  1  1=byte access, 0=word access
op_signed  input  1  byte loads only: 1=sign-extend, 0=zero-extend
reg_index  input  4  register written (load) or read (store)
addr  input  ADDR_W  byte address, little-endian
busy  output  1  request in progress
done  output  1  one-cycle pulse at request completion
fault  output  1  one-cycle pulse with done on rejected request
memory_index  output  4  register-file port index
memory_load  output  16  register-file write data
memory_load_en  output  1  register-file write strobe
memory_store  input  16  register-file read data at memory_index (index 0 reads 0)
bus_req  output  1  bus request
bus_we  output  1  1=write
bus_addr  output  ADDR_W  word-aligned byte address (bit0 always 0)
bus_be  output  2  byte enables; bit0=bits 7:0 (even byte), bit1=bits 15:8
bus_wdata  output  16  write data
bus_ack  input  1  transaction complete; rdata valid this cycle
bus_rdata  input  16  read data

Behaviour:
- Reset values:
  - All outputs are 0; memory_index=RESET_INDEX; state IDLE.
  - rst mid-transaction: next edge drops bus_req, returns to IDLE, and produces no writeback or done, even if bus_ack arrives in that cycle.
- States: IDLE, LATCH, ACCESS, ACCESS2 (only when the macro is set), WRITEBACK.
- IDLE:
  - start=1 latches op_store, op_byte, op_signed, reg_index and addr.
  - memory_index is set to reg_index on that edge.
  - Store goes to LATCH; load goes to ACCESS.
  - Word request with addr[0]=1 goes to ACCESS (split) with the macro; without the macro see Optional Feature.
- start while busy=1 is ignored; there is no queue.
- LATCH (stores only, 1 cycle):
  - bus_wdata is captured from memory_store.
  - Byte stores replicate the low byte into both lanes: {b,b}.
  - Next state ACCESS.
  - Store index 0 therefore writes 0x0000.
- ACCESS:
  - bus_req=1. bus_addr={addr[15:1],0}, bus_we=op_store.
  - bus_be: word access 11; byte access 01 for even addr, 10 for odd addr.
  - All bus outputs stay stable until bus_ack. bus_ack in the first req cycle is valid.
  - On bus_ack, bus_req drops at the next edge.
  - Store: done pulses in the cycle after ack, then IDLE.
  - Load: capture lane data and go to WRITEBACK.
  - Byte-load lane: addr[0] selects rdata[7:0] or rdata[15:8]; the result is extended per op_signed.
- WRITEBACK (1 cycle):
  - memory_load_en=1 and memory_load=result; memory_index still holds the latched index.
  - done=1 in the same cycle; next state IDLE.
  - Loads to index 0 are legal: this is the instruction fetch into the IR.
- Latency with zero-wait ack:
  - Load: start at N, req at N+1, writeback/done at N+2.
  - Store: start at N, LATCH at N+1, req at N+2, done at N+3.
- busy=1 in every non-IDLE state.
- bus_ack while bus_req=0 is ignored.
- memory_load_en is never asserted for stores or faults.
- Integrator requirement: the register file accepts memory_load_en on the falling edge of clk.ph0 within the WRITEBACK cycle.

Optional Feature:
Macro LSU_MISALIGNED_SPLIT_EN.
- Defined: a word access with addr[0]=1 becomes two byte transactions.
  - First: bus_addr=addr-1, be=10, carrying the low byte.
  - ACCESS2: bus_addr=addr+1, be=01, carrying the high byte. addr+1 wraps 0xFFFF to 0x0000.
  - Stores send memory_store[7:0] in lane 1, then memory_store[15:8] in lane 0.
  - Loads assemble {second lane0, first lane1}.
  - done/writeback follow the second ack.
- Undefined: a misaligned word request issues no bus transaction and no writeback. done=1 and fault=1 pulse in the cycle after start, then IDLE.

Test Plan:
- Word load reg 5, addr 0x1234, ack after 2 wait cycles, rdata 0xBEEF -> bus_addr 0x1234, be 11, we 0; one cycle with memory_index 5, memory_load 0xBEEF, memory_load_en 1, done 1.
- Byte load addr 0x0011, rdata 0x80AA: op_signed=1 -> be 10, memory_load 0xFF80; op_signed=0 -> memory_load 0x0080.
- Byte store reg 3=0x12CD to 0x0020 -> bus_addr 0x0020, be 01, wdata 0xCDCD, we 1; done the cycle after ack; memory_load_en never 1.
- Misaligned word load 0x00FF, with macro: rdata 0x3400 at 0x00FE/be 10, then 0x0056 at 0x0100/be 01 -> memory_load 0x5634. Without macro: fault+done, bus_req stays 0.
- rst asserted while bus_req=1 awaiting ack, ack in same cycle -> next cycle bus_req 0, busy 0, done 0, no memory_load_en.
- Store from reg index 0 -> wdata 0x0000; second start during busy -> ignored, exactly one done.
